lzw_byte_reorder: RTL and testbench
===================================

// Module: lzw_byte_reorder
// PURPOSE
//  Downstream stage of the LZW backward decompressor. It receives each decoded string
//  in reverse order (leaf to root) and stores it in a per-string LIFO. It emits the
//  string in forward order as the final recovered payload byte stream.
//  Two ping-pong stack banks let one string drain while the next one fills.
// PARAMETERS
//  DEPTH   32  bytes per stack bank; the maximum LZW string length. Must be a power of 2.
//  AW       5  log2(DEPTH); also the length-counter width.
// PORTS
//  I_sys_clk          in   1   system clock, 250 MHz
//  I_sys_rst          in   1   asynchronous reset, active high
//  I_state_clr        in   1   synchronous clear of the error flag and statistics
//  I_rev_data         in   8   reversed string byte from the decompressor
//  I_rev_data_en      in   1   I_rev_data valid; no backpressure
//  I_rev_last         in   1   qualifies I_rev_data_en; marks the root byte (last in, first out)
//  O_payload_data     out  8   forward-order payload byte
//  O_payload_data_en  out  1   O_payload_data valid
//  O_payload_last     out  1   last byte of a string; coincides with O_payload_data_en
//  O_overflow_err     out  1   sticky: a byte was dropped
// BEHAVIOUR
//  - Reset values: all outputs 0. Both banks are empty, wr_sel=0, rd_sel=0, and all
//    lengths and pointers are 0.
//  - Write side:
//    - Each valid byte is written to bank[wr_sel] at wr_ptr, then wr_ptr is incremented.
//    - On I_rev_last, the bank's length is set to wr_ptr+1, the bank is marked full,
//      wr_sel toggles and wr_ptr clears.
//  - Read side FSM:
//    - IDLE: wait until bank[rd_sel] is full. Load rd_ptr = len-1 and go to POP.
//    - POP: read bank[rd_sel][rd_ptr] each cycle and decrement rd_ptr.
//      When rd_ptr==0, assert O_payload_last with that byte. In the same cycle, clear
//      bank full, toggle rd_sel and return to IDLE.
//    - IDLE->POP costs one cycle, so there is a one-cycle gap between strings.
//  - Output timing:
//    - Memory read plus output register gives 2 cycles of latency.
//    - The first O_payload_data_en occurs 3 cycles after the cycle carrying I_rev_last.
//    - Output is one byte per cycle, with no gaps inside a string.
//  - Upstream rate is at most one byte per 2 cycles, so draining outruns filling and
//    in-order strings never overlap.
//  - Single-byte string (I_rev_last on the first byte): one output byte, with
//    O_payload_data_en and O_payload_last high together.
//  - Overflow, drop rules:
//    - Byte arrives while bank[wr_sel] is still full (both banks busy): drop the byte,
//      set O_overflow_err. If that byte carries I_rev_last, the string is discarded
//      entirely and wr_ptr clears.
//    - wr_ptr==DEPTH-1 without I_rev_last: that byte is stored and treated as the last
//      byte, O_overflow_err is set, and further bytes are dropped until I_rev_last.
//  - Simultaneous events:
//    - A bank release (last pop) and a write into that bank in the same cycle: the
//      write is dropped. The bank becomes free on the following cycle.
//    - I_state_clr together with a new overflow: the overflow wins, so the flag stays 1.
//  - Asynchronous reset mid-string: all stored data and in-flight output are abandoned.
//    There is no partial output after reset deasserts.
// CONFIGURATION
//  LZW_REORDER_STAT_EN defined:
//    - Adds output ports O_string_cnt[31:0] and O_byte_cnt[31:0].
//    - O_string_cnt increments on each O_payload_last. O_byte_cnt increments on each
//      O_payload_data_en.
//    - Both counters wrap at 2^32, reset to 0, and clear on I_state_clr.
//    - A clear and an increment in the same cycle give the value 0.
//  LZW_REORDER_STAT_EN undefined: the ports and counters are absent. All other
//    behaviour is identical.
// TESTING
//  1. Bytes c,b,a (0x63,0x62,0x61) one per 2 cycles, last on 0x61 -> output 61,62,63 on
//     consecutive cycles, last on 63, first byte 3 cycles after the last input.
//  2. Single byte 0x41 with I_rev_last -> one output 0x41 with en=last=1; string_cnt=1,
//     byte_cnt=1 (stats build).
//  3. Back-to-back strings {3,2,1} and {6,5,4} at max input rate -> 1,2,3,4,5,6 with a
//     last pulse after 3 and after 6; no error.
//  4. 33-byte string without last until byte 33 -> first 32 bytes output reversed,
//     byte 33 dropped, O_overflow_err=1. I_state_clr -> 0.
//  5. Strings arriving every cycle with both banks full -> third string's bytes dropped
//     with error set; first two strings output intact.
//  6. Reset asserted mid-POP on a 10-byte string -> outputs 0 immediately; a new string
//     {8,7} after reset gives 7,8.

Source files
------------

// File: rtl/lzw_byte_reorder.sv
`timescale 1ns/1ps
// lzw_byte_reorder
//   Final stage of the LZW backward decompressor. Each decoded string arrives
//   leaf-to-root and is pushed into one of two ping-pong LIFO banks. A bank is
//   drained root-first while the other bank fills, so the output is the forward
//   payload byte stream.
//
//   Optional build macro: LZW_REORDER_STAT_EN adds string/byte statistics ports.
//
// Ports
//   I_sys_clk, I_sys_rst   clock, asynchronous active-high reset
//   I_state_clr            synchronous clear of error flag and statistics
//   I_rev_data[7:0]        reversed string byte, qualified by I_rev_data_en
//   I_rev_last             root byte of the string (qualifies I_rev_data_en)
//   O_payload_data[7:0]    forward-order byte, qualified by O_payload_data_en
//   O_payload_last         final byte of a string
//   O_overflow_err         sticky, set whenever an input byte is dropped
//   O_string_cnt[31:0]     (stats build) strings emitted
//   O_byte_cnt[31:0]       (stats build) bytes emitted
module lzw_byte_reorder #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic        I_sys_clk,
    input  logic        I_sys_rst,
    input  logic        I_state_clr,
    input  logic [7:0]  I_rev_data,
    input  logic        I_rev_data_en,
    input  logic        I_rev_last,
    output logic [7:0]  O_payload_data,
    output logic        O_payload_data_en,
    output logic        O_payload_last,
    output logic        O_overflow_err
`ifdef LZW_REORDER_STAT_EN
    ,
    output logic [31:0] O_string_cnt,
    output logic [31:0] O_byte_cnt
`endif
);

    typedef enum logic {ST_IDLE, ST_POP} state_t;

    state_t         r_state;
    logic [7:0]     r_mem [0:2*DEPTH-1];
    logic [1:0]     r_full;
    // Index of the last stored byte (string length minus one) per bank
    logic [AW-1:0]  r_len [0:1];
    logic           r_wr_sel;
    logic           r_rd_sel;
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    // Set after a truncated string: discard input until its real root byte
    logic           r_drop;

    logic           w_wr_bank_full;
    logic           w_wr_accept;
    logic           w_wr_at_top;
    logic           w_wr_end;
    logic           w_trunc;
    logic           w_in_drop;
    logic           w_pop;
    logic           w_pop_end;

    // A bank released this cycle still reads full, so a same-cycle write is dropped
    assign w_wr_bank_full = r_full[r_wr_sel];
    assign w_wr_accept    = I_rev_data_en && !r_drop && !w_wr_bank_full;
    assign w_wr_at_top    = (r_wr_ptr == AW'(DEPTH - 1));
    assign w_wr_end       = w_wr_accept && (I_rev_last || w_wr_at_top);
    assign w_trunc        = w_wr_accept && !I_rev_last && w_wr_at_top;
    assign w_in_drop      = I_rev_data_en && !w_wr_accept;
    assign w_pop          = (r_state == ST_POP);
    assign w_pop_end      = w_pop && (r_rd_ptr == '0);

    // Stack storage; contents are don't-care until a bank is marked full
    always_ff @(posedge I_sys_clk) begin
        if (w_wr_accept) begin
            r_mem[{r_wr_sel, r_wr_ptr}] <= I_rev_data;
        end
    end

    // Write pointer, bank select, lengths and truncation drop state
    always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
        if (I_sys_rst) begin
            r_wr_ptr <= '0;
            r_wr_sel <= 1'b0;
            r_drop   <= 1'b0;
            r_len[0] <= '0;
            r_len[1] <= '0;
        end else if (I_rev_data_en) begin
            if (r_drop) begin
                if (I_rev_last) begin
                    r_drop <= 1'b0;
                end
            end else if (w_wr_bank_full) begin
                if (I_rev_last) begin
                    r_wr_ptr <= '0;
                end
            end else if (w_wr_end) begin
                r_len[r_wr_sel] <= r_wr_ptr;
                r_wr_sel        <= ~r_wr_sel;
                r_wr_ptr        <= '0;
                r_drop          <= !I_rev_last;
            end else begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
        end
    end

    // Bank full flags: set on string end, cleared on the last pop
    always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
        if (I_sys_rst) begin
            r_full <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_wr_end && (r_wr_sel == 1'(b))) begin
                    r_full[b] <= 1'b1;
                end else if (w_pop_end && (r_rd_sel == 1'(b))) begin
                    r_full[b] <= 1'b0;
                end
            end
        end
    end

    // Read FSM with registered payload outputs
    always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
        if (I_sys_rst) begin
            r_state           <= ST_IDLE;
            r_rd_sel          <= 1'b0;
            r_rd_ptr          <= '0;
            O_payload_data    <= '0;
            O_payload_data_en <= 1'b0;
            O_payload_last    <= 1'b0;
        end else begin
            O_payload_data_en <= 1'b0;
            O_payload_last    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_full[r_rd_sel]) begin
                        r_rd_ptr <= r_len[r_rd_sel];
                        r_state  <= ST_POP;
                    end
                end
                ST_POP: begin
                    O_payload_data    <= r_mem[{r_rd_sel, r_rd_ptr}];
                    O_payload_data_en <= 1'b1;
                    if (r_rd_ptr == '0) begin
                        O_payload_last <= 1'b1;
                        r_rd_sel       <= ~r_rd_sel;
                        r_state        <= ST_IDLE;
                    end else begin
                        r_rd_ptr <= r_rd_ptr - AW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky overflow flag; a new overflow beats a simultaneous clear
    always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
        if (I_sys_rst) begin
            O_overflow_err <= 1'b0;
        end else if (w_in_drop || w_trunc) begin
            O_overflow_err <= 1'b1;
        end else if (I_state_clr) begin
            O_overflow_err <= 1'b0;
        end
    end

`ifdef LZW_REORDER_STAT_EN
    // Statistics advance in step with the payload outputs; clear wins over increment
    always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
        if (I_sys_rst) begin
            O_string_cnt <= '0;
            O_byte_cnt   <= '0;
        end else if (I_state_clr) begin
            O_string_cnt <= '0;
            O_byte_cnt   <= '0;
        end else begin
            if (w_pop) begin
                O_byte_cnt <= O_byte_cnt + 32'd1;
            end
            if (w_pop_end) begin
                O_string_cnt <= O_string_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lzw_byte_reorder.sv
`timescale 1ns/1ps
// Scoreboard bench for lzw_byte_reorder: expected forward bytes are queued as
// each string is sent and matched against the payload stream.
module tb_lzw_byte_reorder;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         cyc;    // required output cycle, -1 when not pinned
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [7:0]  din = '0;
    logic        den = 1'b0;
    logic        dlast = 1'b0;
    logic [7:0]  pdata;
    logic        pen;
    logic        plast;
    logic        perr;
`ifdef LZW_REORDER_STAT_EN
    logic [31:0] scnt;
    logic [31:0] bcnt;
`endif

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   prev_open = 1'b0;
    int   prev_cyc = 0;

    lzw_byte_reorder dut (
        .I_sys_clk         (clk),
        .I_sys_rst         (rst),
        .I_state_clr       (clr),
        .I_rev_data        (din),
        .I_rev_data_en     (den),
        .I_rev_last        (dlast),
        .O_payload_data    (pdata),
        .O_payload_data_en (pen),
        .O_payload_last    (plast),
        .O_overflow_err    (perr)
`ifdef LZW_REORDER_STAT_EN
        ,
        .O_string_cnt      (scnt),
        .O_byte_cnt        (bcnt)
`endif
    );

    always #2 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Output monitor: compare every payload byte against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_open = 1'b0;
        end else if (pen) begin
            if (q.size() == 0) begin
                check("spurious_out", 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                check("out_data", 32'(pdata), 32'(e.data));
                check("out_last", 32'(plast), 32'(e.last));
                if (e.cyc >= 0) check("out_cycle", 32'(cyc), 32'(e.cyc));
            end
            if (prev_open) check("no_gap", 32'(cyc), 32'(prev_cyc + 1));
            prev_open = !plast;
            prev_cyc  = cyc;
        end else if (prev_open) begin
            check("in_string_gap", 32'(pen), 32'd1);
            prev_open = 1'b0;
        end
    end

    task automatic put(input logic [7:0] d, input logic l);
        @(negedge clk);
        din   = d;
        den   = 1'b1;
        dlast = l;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        den   = 1'b0;
        dlast = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    // Send bytes base+n-1 .. base (root last); forward output is base .. base+n-1
    task automatic send_str(input int n, input int base, input bit gap, input bit timed);
        exp_t e;
        int   l_cyc;
        for (int i = 0; i < n; i++) begin
            put(8'(base + n - 1 - i), (i == n - 1));
            if (i == n - 1) begin
                l_cyc = cyc;
                for (int j = 0; j < n; j++) begin
                    e.data = 8'(base + j);
                    e.last = (j == n - 1);
                    e.cyc  = timed ? (l_cyc + 3 + j) : -1;
                    q.push_back(e);
                end
            end
            if (gap) idle(1);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
        check("drain", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        exp_t e;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_en",   32'(pen),   32'd0);
        check("rst_last", 32'(plast), 32'd0);
        check("rst_data", 32'(pdata), 32'd0);
        check("rst_err",  32'(perr),  32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // c,b,a at half rate, pinned latency
        send_str(3, 8'h61, 1'b1, 1'b1);
        wait_drain();

        // Single-byte string
        pulse_clr();
        send_str(1, 8'h41, 1'b1, 1'b1);
        wait_drain();
`ifdef LZW_REORDER_STAT_EN
        check("string_cnt", scnt, 32'd1);
        check("byte_cnt",   bcnt, 32'd1);
`endif

        // Back-to-back strings at maximum input rate
        send_str(3, 1, 1'b1, 1'b1);
        send_str(3, 4, 1'b1, 1'b1);
        wait_drain();
        check("no_err_b2b", 32'(perr), 32'd0);

        // 33-byte string: byte 32 truncates, byte 33 is dropped
        for (int i = 0; i < 33; i++) begin
            put(8'(i + 1), (i == 32));
            if (i == 31) begin
                for (int j = 0; j < 32; j++) begin
                    e.data = 8'(32 - j);
                    e.last = (j == 31);
                    e.cyc  = -1;
                    q.push_back(e);
                end
            end
            idle(1);
        end
        wait_drain();
        check("ovf_err_set", 32'(perr), 32'd1);
        pulse_clr();
        check("ovf_err_clr", 32'(perr), 32'd0);

        // Both banks busy: third string lands on the bank being released
        send_str(2, 8'h10, 1'b0, 1'b0);
        send_str(2, 8'h20, 1'b0, 1'b0);
        put(8'h30, 1'b1);
        idle(1);
        wait_drain();
        check("busy_err_set", 32'(perr), 32'd1);
        pulse_clr();
        check("busy_err_clr", 32'(perr), 32'd0);

        // Reset in the middle of draining a 10-byte string
        send_str(10, 8'h50, 1'b1, 1'b0);
        for (int i = 0; i < 200 && q.size() > 7; i++) @(negedge clk);
        check("mid_pop_reached", 32'(q.size() <= 7), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_en",   32'(pen),   32'd0);
        check("arst_last", 32'(plast), 32'd0);
        check("arst_data", 32'(pdata), 32'd0);
        q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'(pen), 32'd0);
        end
        send_str(2, 7, 1'b1, 1'b1);
        wait_drain();
        check("final_err", 32'(perr), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
